// File: rtl/pid_regfile_pkg.sv
// Shared register map for the multi-channel PID register bank: per-channel word offsets,
// STATUS bit positions and the CTRL commit bit.
package pid_regfile_pkg;

    localparam logic [3:0] OFF_P      = 4'd0;
    localparam logic [3:0] OFF_I      = 4'd1;
    localparam logic [3:0] OFF_D      = 4'd2;
    localparam logic [3:0] OFF_SP     = 4'd3;
    localparam logic [3:0] OFF_CTRL   = 4'd4;
    localparam logic [3:0] OFF_STATUS = 4'd12;
    localparam logic [3:0] OFF_S_I    = 4'd13;
    localparam logic [3:0] OFF_PID_O  = 4'd14;
    localparam logic [3:0] OFF_PWM_O  = 4'd15;

    localparam int N_SHADOW   = 4;
    localparam int N_RW_WORDS = 12;

    localparam int ST_PENDING      = 0;
    localparam int ST_STALE        = 1;
    localparam int ST_WR_ERR       = 2;
    localparam int CTRL_COMMIT_BIT = 0;

    function automatic logic is_ro_offset(input logic [3:0] off);
        return off >= OFF_STATUS;
    endfunction

endpackage

// File: rtl/pid_regfile_ch.sv
// One PID channel: shadow/active coefficients, scratch words, capture registers, status
// and (with PIDRF_STALE_EN) the sensor-staleness watchdog.
module pid_regfile_ch
    import pid_regfile_pkg::*;
#(
    parameter int DATA_W = 16
`ifdef PIDRF_STALE_EN
    ,
    parameter int STALE_MAX = 1000
`endif
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [3:0]        wr_off_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              commit_i,
    input  logic              err_set_i,
    input  logic              status_clr_i,
    input  logic              sens_data_rdy_i,
    input  logic [DATA_W-1:0] sens_data_i,
    input  logic [DATA_W-1:0] pid_o_i,
    input  logic [DATA_W-1:0] pwm_o_i,
    input  logic [3:0]        rd_off_i,
    output logic [DATA_W-1:0] rd_word_o,
    output logic [DATA_W-1:0] p_o,
    output logic [DATA_W-1:0] i_o,
    output logic [DATA_W-1:0] d_o,
    output logic [DATA_W-1:0] sp_o,
    output logic [DATA_W-1:0] s_o,
    output logic              stale_o
);

    logic [DATA_W-1:0] regs   [N_RW_WORDS];
    logic [DATA_W-1:0] active [N_SHADOW];
    logic [DATA_W-1:0] s_i_q;
    logic [DATA_W-1:0] pid_q;
    logic [DATA_W-1:0] pwm_q;
    logic [DATA_W-1:0] status;
    logic              pending;
    logic              wr_err_q;
    logic              stale;
    logic              commit_now;
    logic              reg_wr;
    logic              shadow_wr;

    assign commit_now = commit_i
                      || (wr_en_i && (wr_off_i == OFF_CTRL) && wr_data_i[CTRL_COMMIT_BIT]);
    assign reg_wr     = wr_en_i && (wr_off_i != OFF_CTRL) && !is_ro_offset(wr_off_i);
    assign shadow_wr  = wr_en_i && (wr_off_i <= OFF_SP);

    // Commit copies the shadow as it stood before this cycle's host write, so a
    // colliding write lands only in the shadow and leaves the channel pending.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            for (int k = 0; k < N_RW_WORDS; k++) regs[k] <= '0;
            for (int k = 0; k < N_SHADOW; k++) active[k] <= '0;
            pending  <= 1'b0;
            wr_err_q <= 1'b0;
            s_i_q    <= '0;
            pid_q    <= '0;
            pwm_q    <= '0;
        end else begin
            if (commit_now) begin
                for (int k = 0; k < N_SHADOW; k++) active[k] <= regs[k];
            end
            if (reg_wr) regs[wr_off_i] <= wr_data_i;
            if (shadow_wr) pending <= 1'b1;
            else if (commit_now) pending <= 1'b0;
            if (err_set_i) wr_err_q <= 1'b1;
            else if (status_clr_i) wr_err_q <= 1'b0;
            if (sens_data_rdy_i) s_i_q <= sens_data_i;
            pid_q <= pid_o_i;
            pwm_q <= pwm_o_i;
        end
    end

`ifdef PIDRF_STALE_EN
    localparam int CNT_W = $clog2(STALE_MAX + 1);
    logic [CNT_W-1:0] stale_cnt;

    always_ff @(posedge clk_in) begin
        if (reset) stale_cnt <= '0;
        else if (sens_data_rdy_i) stale_cnt <= '0;
        else if (stale_cnt != CNT_W'(STALE_MAX)) stale_cnt <= stale_cnt + 1'b1;
    end

    assign stale = (stale_cnt == CNT_W'(STALE_MAX));
`else
    assign stale = 1'b0;
`endif

    always_comb begin
        status            = '0;
        status[ST_PENDING] = pending;
        status[ST_STALE]   = stale;
        status[ST_WR_ERR]  = wr_err_q;
    end

    always_comb begin
        rd_word_o = '0;
        case (rd_off_i)
            OFF_CTRL:   rd_word_o = '0;
            OFF_STATUS: rd_word_o = status;
            OFF_S_I:    rd_word_o = s_i_q;
            OFF_PID_O:  rd_word_o = pid_q;
            OFF_PWM_O:  rd_word_o = pwm_q;
            default:    rd_word_o = regs[rd_off_i];
        endcase
    end

    assign p_o     = active[OFF_P[1:0]];
    assign i_o     = active[OFF_I[1:0]];
    assign d_o     = active[OFF_D[1:0]];
    assign sp_o    = active[OFF_SP[1:0]];
    assign s_o     = s_i_q;
    assign stale_o = stale;

endmodule

// File: rtl/pid_regfile.sv
// N_CH-channel PID register bank: host address decode, write rejection and read mux.
// Define PIDRF_STALE_EN to build the per-channel sensor-staleness watchdogs.
module pid_regfile
    import pid_regfile_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int DATA_W    = 16,
    parameter int STALE_MAX = 1000,
    parameter int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter int ADDR_W    = CH_W + 4
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic                   wr_en_i,
    input  logic [ADDR_W-1:0]      wr_addr_i,
    input  logic [DATA_W-1:0]      wr_data_i,
    output logic                   wr_err_o,
    input  logic                   rd_en_i,
    input  logic [ADDR_W-1:0]      rd_addr_i,
    output logic [DATA_W-1:0]      rd_data_o,
    output logic                   rd_valid_o,
    input  logic [N_CH-1:0]        commit_i,
    input  logic [N_CH-1:0]        sens_data_rdy_i,
    input  logic [N_CH*DATA_W-1:0] sens_data_i,
    input  logic [N_CH*DATA_W-1:0] pid_o_i,
    input  logic [N_CH*DATA_W-1:0] pwm_o_i,
    output logic [N_CH*DATA_W-1:0] p_o,
    output logic [N_CH*DATA_W-1:0] i_o,
    output logic [N_CH*DATA_W-1:0] d_o,
    output logic [N_CH*DATA_W-1:0] sp_o,
    output logic [N_CH*DATA_W-1:0] s_o,
    output logic [N_CH-1:0]        stale_o
);

    if (N_CH < 1 || N_CH > 16 || STALE_MAX < 1) begin : g_bad_params
        $error("pid_regfile: N_CH must be 1..16 and STALE_MAX at least 1");
    end

    logic [CH_W-1:0]   wr_ch;
    logic [3:0]        wr_off;
    logic [CH_W-1:0]   rd_ch;
    logic [3:0]        rd_off;
    logic              wr_ch_ok;
    logic              wr_reject;
    logic              wr_legal;
    logic [DATA_W-1:0] rd_mux;
    logic [DATA_W-1:0] ch_rd_word [N_CH];

    assign wr_ch     = wr_addr_i[ADDR_W-1:4];
    assign wr_off    = wr_addr_i[3:0];
    assign rd_ch     = rd_addr_i[ADDR_W-1:4];
    assign rd_off    = rd_addr_i[3:0];
    assign wr_ch_ok  = {1'b0, wr_ch} < (CH_W + 1)'(N_CH);
    assign wr_reject = wr_en_i && (!wr_ch_ok || is_ro_offset(wr_off));
    assign wr_legal  = wr_en_i && !wr_reject;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic ch_wr_hit;
        logic ch_rd_hit;

        assign ch_wr_hit = (wr_ch == CH_W'(c));
        assign ch_rd_hit = (rd_ch == CH_W'(c));

        pid_regfile_ch #(
            .DATA_W          (DATA_W)
`ifdef PIDRF_STALE_EN
            ,
            .STALE_MAX       (STALE_MAX)
`endif
        ) u_ch (
            .clk_in          (clk_in),
            .reset           (reset),
            .wr_en_i         (wr_legal && ch_wr_hit),
            .wr_off_i        (wr_off),
            .wr_data_i       (wr_data_i),
            .commit_i        (commit_i[c]),
            .err_set_i       (wr_reject && ch_wr_hit),
            .status_clr_i    (rd_en_i && ch_rd_hit && (rd_off == OFF_STATUS)),
            .sens_data_rdy_i (sens_data_rdy_i[c]),
            .sens_data_i     (sens_data_i[c*DATA_W +: DATA_W]),
            .pid_o_i         (pid_o_i[c*DATA_W +: DATA_W]),
            .pwm_o_i         (pwm_o_i[c*DATA_W +: DATA_W]),
            .rd_off_i        (rd_off),
            .rd_word_o       (ch_rd_word[c]),
            .p_o             (p_o[c*DATA_W +: DATA_W]),
            .i_o             (i_o[c*DATA_W +: DATA_W]),
            .d_o             (d_o[c*DATA_W +: DATA_W]),
            .sp_o            (sp_o[c*DATA_W +: DATA_W]),
            .s_o             (s_o[c*DATA_W +: DATA_W]),
            .stale_o         (stale_o[c])
        );
    end

    // Addresses beyond the last channel match no entry and read back as zero.
    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (rd_ch == CH_W'(c)) rd_mux = ch_rd_word[c];
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
            wr_err_o   <= 1'b0;
        end else begin
            rd_valid_o <= rd_en_i;
            if (rd_en_i) rd_data_o <= rd_mux;
            wr_err_o   <= wr_reject;
        end
    end

endmodule
